// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, device ACK check.
// Optional device-clock watchdog is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       KB_clk,
    input  logic       data,
    output logic       kb_clk_drive_low,
    output logic       kb_data_drive_low,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    // One counter serves inhibit/setup timing and, when enabled, the watchdog;
    // it is sized for the largest limit so both builds share one width.
    localparam int unsigned PRE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned CNT_MAX = (PRE_MAX > TIMEOUT_CYCLES) ? PRE_MAX : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic             clk_s1, clk_s2, clk_prev;
    logic             data_s1, data_s2;
    logic             fe;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [9:0]       shift;
    logic             ack_ok;

    // Synchronizers reset to the idle (high) line level so no edge is seen out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= KB_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= data;
            data_s2  <= data_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            idx               <= '0;
            shift             <= '0;
            ack_ok            <= 1'b0;
            tx_ready          <= 1'b1;
            kb_clk_drive_low  <= 1'b0;
            kb_data_drive_low <= 1'b0;
            tx_done           <= 1'b0;
            tx_error          <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift             <= {1'b1, ~^tx_data, tx_data};
                        cnt               <= '0;
                        state             <= S_INHIBIT;
                        tx_ready          <= 1'b0;
                        kb_clk_drive_low  <= 1'b1;
                        kb_data_drive_low <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt               <= '0;
                        state             <= S_SETUP;
                        kb_data_drive_low <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt              <= '0;
                        idx              <= '0;
                        state            <= S_SEND;
                        kb_clk_drive_low <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    // Start bit stays driven until the first device edge; shift[9]=1 releases data as stop.
                    if (fe) begin
                        kb_data_drive_low <= ~shift[idx];
                        if (idx == 4'd9) begin
                            state <= S_ACK;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (fe) begin
                        ack_ok <= ~data_s2;
                        state  <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_s2 && data_s2) begin
                        tx_done  <= ack_ok;
                        tx_error <= ~ack_ok;
                        tx_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state             <= S_IDLE;
                    tx_ready          <= 1'b1;
                    kb_clk_drive_low  <= 1'b0;
                    kb_data_drive_low <= 1'b0;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides any same-cycle transition above.
            if (state == S_SEND || state == S_ACK || state == S_WAIT_IDLE) begin
                if (fe) begin
                    cnt <= '0;
                end else if (cnt == TO_LAST) begin
                    cnt               <= '0;
                    state             <= S_IDLE;
                    tx_ready          <= 1'b1;
                    kb_clk_drive_low  <= 1'b0;
                    kb_data_drive_low <= 1'b0;
                    tx_done           <= 1'b0;
                    tx_error          <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
`endif
        end
    end

endmodule
